// File: rtl/dvi_timing_pkg.sv
// dvi_timing_pkg: FSM encoding, default 720p60 timing and derived raster totals
package dvi_timing_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  localparam int CNT_W = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int DEF_H_DISP = 1280;
  localparam int DEF_H_FRONT = 110;
  localparam int DEF_H_SYNC = 40;
  localparam int DEF_H_BACK = 220;
  localparam int DEF_V_DISP = 720;
  localparam int DEF_V_FRONT = 5;
  localparam int DEF_V_SYNC = 5;
  localparam int DEF_V_BACK = 20;
  localparam bit DEF_SYNC_POL = 1'b1;
  function automatic int h_total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction
  function automatic int v_total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction
endpackage

// File: rtl/dvi_timing_counter.sv
// dvi_timing_counter: horizontal/vertical raster position counters with clear
module dvi_timing_counter
  import dvi_timing_pkg::*;
#(
  parameter int H_TOTAL = 1650,
  parameter int V_TOTAL = 750
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_end,
  output logic             frame_end
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;
  assign line_end = h_cnt_q == H_LAST;
  assign frame_end = line_end && v_cnt_q == V_LAST;
  // clear pins the origin; otherwise step h, carrying into v at each line end
  always_comb begin
    h_cnt_d = clr ? '0 : !en ? h_cnt_q : line_end ? '0 : h_cnt_q + ONE;
    v_cnt_d = clr ? '0 : !(en && line_end) ? v_cnt_q : frame_end ? '0 : v_cnt_q + ONE;
  end
  // position registers
  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
endmodule

// File: rtl/dvi_video_timing_ctrl.sv
// dvi_video_timing_ctrl: DVI raster timing, pixel fetch and frame-aligned start/stop
module dvi_video_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [23:0] pixel_data,
  output logic        pixel_req,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        frame_start,
  output logic        busy,
  output logic [23:0] video_din,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de
);
  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_SYNC + V_BACK + V_DISP);
  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_timing_range
    $error("dvi_video_timing_ctrl: timing totals exceed the 12-bit counter range");
  end
  state_e state_q, state_d;
  logic [CNT_W-1:0] h_cnt, v_cnt, pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [23:0] video_din_q, video_din_d;
  logic line_end, frame_end, wrap, running;
  logic pixel_req_q, pixel_req_d, frame_start_q, frame_start_d;
  logic hs1_q, hs1_d, vs1_q, vs1_d, v1_q, de2_q, hs2_q, vs2_q, v2_q;
  logic video_de_q, video_hsync_q, video_hsync_d, video_vsync_q, video_vsync_d;
  assign running = state_q != IDLE;
  assign wrap = line_end && frame_end;
  dvi_timing_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_counter (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .en        (running),
    .clr       (!running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .line_end  (line_end),
    .frame_end (frame_end)
  );
  // run whenever enabled; without enable, finish the current frame before idling
  always_comb begin
    state_d = enable ? RUN : (state_q == IDLE || wrap) ? IDLE : DRAIN;
    frame_start_d = state_d == RUN && (!running || wrap);
  end
  // stage 1 decodes the counters; stages 2-3 delay sync/de and capture the source pixel
  always_comb begin
    pixel_req_d = running && h_cnt >= H_ACT_S && h_cnt < H_ACT_E && v_cnt >= V_ACT_S && v_cnt < V_ACT_E;
    pixel_x_d = pixel_req_d ? h_cnt - H_ACT_S : '0;
    pixel_y_d = pixel_req_d ? v_cnt - V_ACT_S : '0;
    hs1_d = running && h_cnt < H_SYNC_E;
    vs1_d = running && v_cnt < V_SYNC_E;
    video_din_d = de2_q ? pixel_data : '0;
    video_hsync_d = hs2_q ? SYNC_POL : !SYNC_POL;
    video_vsync_d = vs2_q ? SYNC_POL : !SYNC_POL;
  end
  // state and pipeline registers; idle stages flush to the reset levels
  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      frame_start_q <= 1'b0;
      pixel_req_q <= 1'b0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      v1_q <= 1'b0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      v2_q <= 1'b0;
      video_de_q <= 1'b0;
      video_din_q <= '0;
      video_hsync_q <= !SYNC_POL;
      video_vsync_q <= !SYNC_POL;
    end else begin
      state_q <= state_d;
      frame_start_q <= frame_start_d;
      pixel_req_q <= pixel_req_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      v1_q <= running;
      de2_q <= pixel_req_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      v2_q <= v1_q;
      video_de_q <= de2_q;
      video_din_q <= video_din_d;
      video_hsync_q <= video_hsync_d;
      video_vsync_q <= video_vsync_d;
    end
  assign pixel_req = pixel_req_q;
  assign pixel_x = pixel_x_q;
  assign pixel_y = pixel_y_q;
  assign frame_start = frame_start_q;
  assign busy = running || v1_q || v2_q;
  assign video_din = video_din_q;
  assign video_hsync = video_hsync_q;
  assign video_vsync = video_vsync_q;
  assign video_de = video_de_q;
endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// tb_dvi_video_timing_ctrl: frame-position reference model against a small raster plus a 720p smoke run
module tb_dvi_video_timing_ctrl;
  localparam int HD = 4, HF = 2, HS = 3, HB = 1;
  localparam int VD = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic en_d = 1'b0;
  logic [23:0] pixel_data, video_din, d_din, src_d, junk;
  logic [11:0] pixel_x, pixel_y, d_x, d_y;
  logic pixel_req, frame_start, busy, video_hsync, video_vsync, video_de, src_v;
  logic d_req, d_fs, d_busy, d_hs, d_vs, d_de;
  int n_chk = 0;
  int n_fail = 0;
  int seg_de, seg_fs;
  always #5 pclk = ~pclk;
  dvi_video_timing_ctrl #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .pixel_data(pixel_data),
    .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .busy(busy), .video_din(video_din),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de)
  );
  dvi_video_timing_ctrl dut_720p (
    .pclk(pclk), .reset_n(reset_n), .enable(en_d), .pixel_data(24'h0),
    .pixel_req(d_req), .pixel_x(d_x), .pixel_y(d_y),
    .frame_start(d_fs), .busy(d_busy), .video_din(d_din),
    .video_hsync(d_hs), .video_vsync(d_vs), .video_de(d_de)
  );
  // frame source: answers each request one cycle later with x + 16*y, junk otherwise
  always @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      src_v <= 1'b0;
      src_d <= '0;
      junk <= '0;
    end else begin
      src_v <= pixel_req;
      src_d <= 24'(pixel_x) + 24'(pixel_y) * 24'd16;
      junk <= 24'($urandom);
    end
  assign pixel_data = src_v ? src_d : junk;
  typedef struct {bit run; bit act; bit hs; bit vs; bit fs; int x; int y;} info_t;
  typedef struct {bit en; int cycles; int exp_de; int exp_fs; bit exp_busy;} seg_t;
  info_t hist [4];
  int mode, pos;
  function automatic info_t info(input int m, input int p);
    info_t r;
    int h, v;
    h = p % HT;
    v = p / HT;
    r.run = m != 0;
    r.act = r.run && h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD;
    r.x = r.act ? h - (HS + HB) : 0;
    r.y = r.act ? v - (VS + VB) : 0;
    r.hs = r.run && h < HS;
    r.vs = r.run && v < VS;
    r.fs = m == 1 && p == 0;
    return r;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    mode = 0;
    pos = 0;
    for (int i = 0; i < 4; i++) hist[i] = info(0, 0);
  endtask
  // one pixel clock: advance the frame-position model, then compare on the falling edge
  task automatic tick();
    @(posedge pclk);
    if (mode == 0) begin
      mode = enable ? 1 : 0;
      pos = 0;
    end else if (enable) begin
      mode = 1;
      pos = (pos + 1) % FT;
    end else if (pos == FT - 1) begin
      mode = 0;
      pos = 0;
    end else begin
      mode = 2;
      pos++;
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = info(mode, pos);
    @(negedge pclk);
    chk("frame_start", frame_start, hist[0].fs);
    chk("busy", busy, hist[0].run || hist[1].run || hist[2].run);
    chk("pixel_req", pixel_req, hist[1].act);
    chk("pixel_x", pixel_x, hist[1].x);
    chk("pixel_y", pixel_y, hist[1].y);
    chk("video_de", video_de, hist[3].act);
    chk("video_din", video_din, hist[3].act ? hist[3].x + 16 * hist[3].y : 0);
    chk("video_hsync", video_hsync, hist[3].hs);
    chk("video_vsync", video_vsync, hist[3].vs);
    seg_de += int'(video_de);
    seg_fs += int'(frame_start);
  endtask
  task automatic chk_idle_outputs(input string n);
    chk({n, "_req"}, pixel_req, 0);
    chk({n, "_xy"}, int'(pixel_x) + int'(pixel_y), 0);
    chk({n, "_fs"}, frame_start, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_din"}, video_din, 0);
    chk({n, "_hsync"}, video_hsync, 0);
    chk({n, "_vsync"}, video_vsync, 0);
    chk({n, "_de"}, video_de, 0);
  endtask
  seg_t segs [9];
  int d_hs_n, d_vs_n, d_fs_n, d_misc;
  initial begin
    segs = '{'{1'b0, 20, 0, 0, 1'b0}, '{1'b1, 120, 24, 2, 1'b1}, '{1'b0, 10, 0, 0, 1'b0},
             '{1'b1, 25, 0, 1, 1'b1}, '{1'b0, 60, 12, 0, 1'b0}, '{1'b1, 30, 3, 1, 1'b1},
             '{1'b0, 5, 1, 0, 1'b1}, '{1'b1, 40, 8, 1, 1'b1}, '{1'b0, 70, 12, 0, 1'b0}};
    repeat (3) @(negedge pclk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    model_reset();
    for (int s = 0; s < 9; s++) begin
      enable = segs[s].en;
      seg_de = 0;
      seg_fs = 0;
      repeat (segs[s].cycles) tick();
      chk($sformatf("seg%0d_de_count", s), seg_de, segs[s].exp_de);
      chk($sformatf("seg%0d_fs_count", s), seg_fs, segs[s].exp_fs);
      chk($sformatf("seg%0d_busy_end", s), busy, segs[s].exp_busy);
    end
    enable = 1'b1;
    repeat (36) tick();
    chk("pre_reset_req", pixel_req, 1);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("async_reset");
    enable = 1'b0;
    repeat (2) @(negedge pclk);
    chk_idle_outputs("held_reset");
    reset_n = 1'b1;
    model_reset();
    enable = 1'b1;
    seg_de = 0;
    seg_fs = 0;
    repeat (FT) tick();
    chk("post_reset_de_count", seg_de, 12);
    chk("post_reset_fs_count", seg_fs, 1);
    for (int r = 0; r < 14; r++) begin
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 80)) tick();
    end
    enable = 1'b0;
    repeat (FT + 5) tick();
    chk("random_end_busy", busy, 0);
    en_d = 1'b1;
    d_hs_n = 0;
    d_vs_n = 0;
    d_fs_n = 0;
    d_misc = 0;
    repeat (3300) begin
      tick();
      d_hs_n += int'(d_hs);
      d_vs_n += int'(d_vs);
      d_fs_n += int'(d_fs);
      d_misc += int'(d_req) + int'(d_de) + int'(d_x != 0) + int'(d_y != 0) + int'(d_din != 0);
    end
    chk("720p_hsync_cycles", d_hs_n, 80);
    chk("720p_vsync_cycles", d_vs_n, 3297);
    chk("720p_frame_start", d_fs_n, 1);
    chk("720p_no_active", d_misc, 0);
    chk("720p_busy", d_busy, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
